rv_if_pc_ctrl: RTL and testbench

- Instruction-fetch PC controller, directly downstream of the 2-bit branch predictor.
- Consumes the predictor's IF_predict / IF_flush pair and owns the fetch PC register.
- Chooses the next PC from four sources: reset, EX misprediction recovery, ID predicted-taken redirect, or sequential PC+4.
- Records the alternate (not-chosen) path of each ID-stage branch so that EX recovery needs no recomputation.
- Drives squash strobes to the IF/ID and ID/EX pipeline registers.

---
 rtl/rv_if_pc_ctrl_if.sv | 40 ++++
 rtl/rv_if_pc_ctrl.sv | 127 ++++++++++++
 tb/tb_rv_if_pc_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rv_if_pc_ctrl_if.sv
// Fetch-PC controller bus: hazard/predictor inputs, ID branch information,
// and the fetch address, squash strobes and predictor index driven back.
// With RV_IFPC_PERF_CNT_EN defined the bus also carries the redirect and
// flush event counters.
interface rv_if_pc_ctrl_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            IF_predict_i;
  logic            IF_flush_i;
  logic            ID_branch_i;
  logic [XLEN-1:0] ID_pc_i;
  logic [XLEN-1:0] ID_target_i;
  logic [XLEN-1:0] IF_pc_o;
  logic            IF_kill_o;
  logic            ID_kill_o;
  logic [3:0]      ID_bpb_addr_o;
`ifdef RV_IFPC_PERF_CNT_EN
  logic [31:0]     redirect_cnt_o;
  logic [31:0]     flush_cnt_o;
`endif

  // Controller side.
  modport slave (
    input  stall_i, IF_predict_i, IF_flush_i, ID_branch_i, ID_pc_i, ID_target_i,
`ifdef RV_IFPC_PERF_CNT_EN
    output redirect_cnt_o, flush_cnt_o,
`endif
    output IF_pc_o, IF_kill_o, ID_kill_o, ID_bpb_addr_o
  );

  // Pipeline / predictor side.
  modport master (
    output stall_i, IF_predict_i, IF_flush_i, ID_branch_i, ID_pc_i, ID_target_i,
`ifdef RV_IFPC_PERF_CNT_EN
    input  redirect_cnt_o, flush_cnt_o,
`endif
    input  IF_pc_o, IF_kill_o, ID_kill_o, ID_bpb_addr_o
  );
endinterface

// File: rtl/rv_if_pc_ctrl.sv
// Instruction-fetch PC controller. Owns the fetch PC and selects the next
// address from EX mispredict recovery (alt_q), an ID predicted-taken
// redirect, a hazard hold, or sequential PC+4. Each non-stalled ID branch
// records the path it did not take in alt_q, so recovery one cycle later
// is a plain register load.
// Optional feature macro: RV_IFPC_PERF_CNT_EN (saturating redirect/flush
// event counters).
module rv_if_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic          clk,
  input  logic          rstn,
  rv_if_pc_ctrl_if.slave bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] PC_INIT    = XLEN'(RESET_PC) & ALIGN_MASK;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] alt_q, alt_d;
  logic            pend_q, pend_d;
  logic            if_kill_s, id_kill_s;
  logic            redirect_s, flush_s;
  logic [XLEN-1:0] target_al_s;
  logic [XLEN-1:0] id_seq_s;

  assign target_al_s = bus.ID_target_i & ALIGN_MASK;
  assign id_seq_s    = (bus.ID_pc_i + PC_STEP) & ALIGN_MASK;

  // Next-PC selection, alternate-path capture and squash strobes.
  always_comb begin
    pc_d       = pc_q;
    alt_d      = alt_q;
    pend_d     = pend_q;
    if_kill_s  = 1'b0;
    id_kill_s  = 1'b0;
    redirect_s = 1'b0;
    flush_s    = 1'b0;

    if (bus.IF_flush_i) begin
      // Wrong-path ID content is discarded: no capture, no redirect.
      flush_s   = 1'b1;
      pc_d      = alt_q;
      if_kill_s = 1'b1;
      id_kill_s = 1'b1;
      pend_d    = 1'b0;
    end else if (!bus.stall_i) begin
      if (bus.IF_predict_i && bus.ID_branch_i) begin
        redirect_s = 1'b1;
        pc_d       = target_al_s;
        if_kill_s  = 1'b1;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
      if (bus.ID_branch_i) begin
        alt_d  = bus.IF_predict_i ? id_seq_s : target_al_s;
        pend_d = 1'b1;
      end else begin
        pend_d = 1'b0;
      end
    end else begin
      // Stalled: PC, alternate path and pending flag all hold; a
      // predicted-taken branch is re-evaluated once the stall drops.
      pc_d = pc_q;
    end
  end

  // Fetch PC, alternate path and pending-recovery state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q   <= PC_INIT;
      alt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      alt_q  <= alt_d;
      pend_q <= pend_d;
    end
  end

  assign bus.IF_pc_o       = pc_q;
  assign bus.IF_kill_o     = if_kill_s & rstn;
  assign bus.ID_kill_o     = id_kill_s & rstn;
  assign bus.ID_bpb_addr_o = bus.ID_pc_i[5:2];

`ifdef RV_IFPC_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters for accepted redirects and flushes.
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    if (redirect_s && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
      redirect_cnt_d = redirect_cnt_q + 32'd1;
    end else begin
      redirect_cnt_d = redirect_cnt_q;
    end
    if (flush_s && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_cnt_q <= 32'd0;
      flush_cnt_q    <= 32'd0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign bus.redirect_cnt_o = redirect_cnt_q;
  assign bus.flush_cnt_o    = flush_cnt_q;
`else
  // Event strobes only feed the optional counters.
  logic unused_evt_s;
  assign unused_evt_s = redirect_s ^ flush_s;
`endif

endmodule

// File: tb/tb_rv_if_pc_ctrl.sv
// Directed bench for rv_if_pc_ctrl with RESET_PC = 32'h100.
module tb_rv_if_pc_ctrl;
  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  rv_if_pc_ctrl_if #(.XLEN(32)) bus ();

  rv_if_pc_ctrl #(.RESET_PC(32'h0000_0100), .XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic pr, input logic fl, input logic br,
                       input logic [31:0] idpc, input logic [31:0] tgt);
    bus.stall_i      = st;
    bus.IF_predict_i = pr;
    bus.IF_flush_i   = fl;
    bus.ID_branch_i  = br;
    bus.ID_pc_i      = idpc;
    bus.ID_target_i  = tgt;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Move to the next sampling point, mid-cycle after the active edge.
  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstn  = 1'b0;
    // Flush asserted during reset must not leak onto the kill strobes.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    next();
    chk("rst_pc", bus.IF_pc_o, 32'h100);
    chk("rst_ifkill", {31'd0, bus.IF_kill_o}, 32'd0);
    chk("rst_idkill", {31'd0, bus.ID_kill_o}, 32'd0);
    idle();
    next();
    rstn = 1'b1;
    #1;
    chk("seq_100", bus.IF_pc_o, 32'h100);
    chk("seq_kill", {31'd0, bus.IF_kill_o}, 32'd0);
    next();
    chk("seq_104", bus.IF_pc_o, 32'h104);
    next();
    chk("seq_108", bus.IF_pc_o, 32'h108);

    // Redirect to 0x20 (ID_pc 0x10 -> alt 0x14).
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h20);
    chk("redir20_ifkill", {31'd0, bus.IF_kill_o}, 32'd1);
    chk("redir20_idkill", {31'd0, bus.ID_kill_o}, 32'd0);
    next();
    chk("redir20_pc", bus.IF_pc_o, 32'h20);

    // Stall three edges at 0x20.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("stall_ifkill", {31'd0, bus.IF_kill_o}, 32'd0);
    next();
    chk("stall_1", bus.IF_pc_o, 32'h20);
    next();
    chk("stall_2", bus.IF_pc_o, 32'h20);
    next();
    chk("stall_3", bus.IF_pc_o, 32'h20);
    idle();
    next();
    chk("stall_rel", bus.IF_pc_o, 32'h24);

    // Predicted-taken branch at 0x40 -> 0x80, then mispredict to 0x44.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h80);
    chk("tk_ifkill", {31'd0, bus.IF_kill_o}, 32'd1);
    chk("tk_idkill", {31'd0, bus.ID_kill_o}, 32'd0);
    chk("tk_bpb", {28'd0, bus.ID_bpb_addr_o}, 32'h0);
    next();
    chk("tk_pc", bus.IF_pc_o, 32'h80);
    idle();
    chk("tk_kill_once", {31'd0, bus.IF_kill_o}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("tk_fl_ifkill", {31'd0, bus.IF_kill_o}, 32'd1);
    chk("tk_fl_idkill", {31'd0, bus.ID_kill_o}, 32'd1);
    next();
    chk("tk_fl_pc", bus.IF_pc_o, 32'h44);

    // Not-taken branch (target low bits set, must be masked), then mispredict.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h5C, 32'h83);
    chk("nt_ifkill", {31'd0, bus.IF_kill_o}, 32'd0);
    chk("nt_bpb", {28'd0, bus.ID_bpb_addr_o}, 32'h7);
    next();
    chk("nt_seq", bus.IF_pc_o, 32'h48);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    next();
    chk("nt_fl_pc", bus.IF_pc_o, 32'h80);

    // Capture alt 0x200, then flush together with stall and a new branch.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h200);
    next();
    chk("cap_seq", bus.IF_pc_o, 32'h84);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h300);
    chk("flst_ifkill", {31'd0, bus.IF_kill_o}, 32'd1);
    chk("flst_idkill", {31'd0, bus.ID_kill_o}, 32'd1);
    next();
    chk("flst_pc", bus.IF_pc_o, 32'h200);
    // Protocol-error flush: alt_q must still be 0x200 (no capture above).
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    next();
    chk("nocap_pc", bus.IF_pc_o, 32'h200);

    // Predicted-taken branch during stall is deferred.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h500);
    chk("def_ifkill", {31'd0, bus.IF_kill_o}, 32'd0);
    next();
    chk("def_hold", bus.IF_pc_o, 32'h200);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h500);
    chk("def_rel_kill", {31'd0, bus.IF_kill_o}, 32'd1);
    next();
    chk("def_rel_pc", bus.IF_pc_o, 32'h500);

    // Wraparound of PC+4.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'hFFFF_FFFF);
    next();
    chk("wrap_tgt", bus.IF_pc_o, 32'hFFFF_FFFC);
    idle();
    next();
    chk("wrap_zero", bus.IF_pc_o, 32'h0);

    // Asynchronous reset mid-cycle.
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_pc", bus.IF_pc_o, 32'h100);
`ifdef RV_IFPC_PERF_CNT_EN
    chk("cnt_rst_redir", bus.redirect_cnt_o, 32'd0);
    chk("cnt_rst_flush", bus.flush_cnt_o, 32'd0);
`endif
    next();
    rstn = 1'b1;
    #1;
    chk("post_rst_pc", bus.IF_pc_o, 32'h100);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h10);
    next();
    chk("cnt_r1_pc", bus.IF_pc_o, 32'h10);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 32'h30);
    next();
    chk("cnt_r2_pc", bus.IF_pc_o, 32'h30);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    next();
    chk("cnt_fl_pc", bus.IF_pc_o, 32'hC);
`ifdef RV_IFPC_PERF_CNT_EN
    chk("cnt_redir", bus.redirect_cnt_o, 32'd2);
    chk("cnt_flush", bus.flush_cnt_o, 32'd1);
`endif
    idle();
    next();
    chk("cnt_seq", bus.IF_pc_o, 32'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
